fp_decoder: RTL and testbench

FP_DECODER -- requirements
Module: fp_decoder

---
 rtl/fp_decoder.sv | 103 ++++++++++
 tb/tb_fp_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_decoder.sv
// Serial decoder of a sign/3-bit-exponent/4-bit-significand word into a 12-bit two's complement value.
// Optional build macro FP_DECODER_MIDPOINT_EN selects midpoint reconstruction ((2F+1)<<(E-1) for E>=1).
module fp_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_s,
  input  logic [2:0]  in_e,
  input  logic [3:0]  in_f,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_d
);

  localparam int DATA_W = 12;
  localparam int MAG_W  = 11;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] SIGN  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic                     sign_q, sign_d;
  logic [MAG_W-1:0]         mag_q, mag_d;
  logic [2:0]               cnt_q, cnt_d;
  logic signed [DATA_W-1:0] out_d_q, out_d_d;

  // Zero magnitude negates to zero, so a negative zero can never be produced.
  function automatic logic signed [DATA_W-1:0] apply_sign(input logic neg,
                                                          input logic [MAG_W-1:0] mag);
    logic signed [DATA_W-1:0] v;
    v = signed'({1'b0, mag});
    apply_sign = neg ? -v : v;
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_d     = out_d_q;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    out_d_d = out_d_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_s;
          state_d = SHIFT;
`ifdef FP_DECODER_MIDPOINT_EN
          // The implied half-LSB is appended as bit 0, costing one shift step.
          if (in_e != 3'd0) begin
            mag_d = {6'd0, in_f, 1'b1};
            cnt_d = in_e - 3'd1;
          end else begin
            mag_d = {7'd0, in_f};
            cnt_d = in_e;
          end
`else
          mag_d = {7'd0, in_f};
          cnt_d = in_e;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q == 3'd0) begin
          state_d = SIGN;
        end else begin
          mag_d = {mag_q[MAG_W-2:0], 1'b0};
          cnt_d = cnt_q - 3'd1;
        end
      end
      SIGN: begin
        out_d_d = apply_sign(sign_q, mag_q);
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      cnt_q   <= '0;
      out_d_q <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      out_d_q <= out_d_d;
    end
  end

endmodule

// File: tb/tb_fp_decoder.sv
// Directed, table-driven bench for fp_decoder; expectations follow FP_DECODER_MIDPOINT_EN when defined.
module tb_fp_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_s;
  logic [2:0]  in_e;
  logic [3:0]  in_f;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_d;

  int checks   = 0;
  int failures = 0;

  fp_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_e      (in_e),
    .in_f      (in_f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d     (out_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [2:0]  e;
    logic [3:0]  f;
    logic [11:0] d;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic scramble_inputs();
    in_valid = 1'b1;
    in_s = 1'($urandom_range(0, 1));
    in_e = 3'($urandom_range(0, 7));
    in_f = 4'($urandom_range(0, 15));
  endtask

  task automatic run_word(input vec_t v);
    int n;
    logic busy_ready;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_s = v.s; in_e = v.e; in_f = v.f;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    busy_ready = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) busy_ready = 1'b1;
      scramble_inputs();
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(v.lat));
    chk("out_d", 32'(out_d), 32'(v.d));
    chk("busy_in_ready", 32'(busy_ready), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      scramble_inputs();
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_d", 32'(out_d), 32'(v.d));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("leave_out_valid", 32'(out_valid), 32'd0);
    chk("leave_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic reset_midflight(input logic s, input logic [2:0] e, input logic [3:0] f,
                                 input int edges);
    logic seen;
    @(negedge clk);
    in_valid = 1'b1; in_s = s; in_e = e; in_f = f;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (edges) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_d", 32'(out_d), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    out_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen = 1'b1;
    end
    out_ready = 1'b0;
    chk("post_rst_quiet", 32'(seen), 32'd0);
  endtask

  task automatic back_to_back();
    logic [11:0] exp_q[3];
    logic [3:0]  wf[3];
    logic [2:0]  we[3];
    logic        ws[3];
    int widx, oidx, cyc;
    logic overlap;
    ws = '{1'b0, 1'b1, 1'b0}; we = '{3'd0, 3'd2, 3'd1}; wf = '{4'd5, 4'd3, 4'd15};
`ifdef FP_DECODER_MIDPOINT_EN
    exp_q = '{12'h005, 12'hFF2, 12'h01F};
`else
    exp_q = '{12'h005, 12'hFF4, 12'h01E};
`endif
    widx = 0; oidx = 0; cyc = 0; overlap = 1'b0;
    out_ready = 1'b1;
    while (oidx < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid && in_ready) overlap = 1'b1;
      if (out_valid) begin
        chk("b2b_out_d", 32'(out_d), 32'(exp_q[oidx]));
        oidx++;
      end
      if (in_ready) begin
        if (widx < 3) begin
          in_valid = 1'b1; in_s = ws[widx]; in_e = we[widx]; in_f = wf[widx];
          widx++;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        scramble_inputs();
      end
    end
    in_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) oidx++;
    end
    out_ready = 1'b0;
    chk("b2b_count", 32'(oidx), 32'd3);
    chk("b2b_overlap", 32'(overlap), 32'd0);
  endtask

  initial begin
`ifdef FP_DECODER_MIDPOINT_EN
    vecs[0] = '{1'b0, 3'd0, 4'd5,  12'h005, 2, 0};
    vecs[1] = '{1'b0, 3'd7, 4'd15, 12'h7C0, 8, 0};
    vecs[2] = '{1'b1, 3'd3, 4'd8,  12'hFBC, 4, 1};
    vecs[3] = '{1'b1, 3'd5, 4'd0,  12'hFF0, 6, 4};
    vecs[4] = '{1'b1, 3'd0, 4'd1,  12'hFFF, 2, 0};
    vecs[5] = '{1'b0, 3'd4, 4'd9,  12'h098, 5, 0};
    vecs[6] = '{1'b1, 3'd7, 4'd15, 12'h840, 8, 0};
    vecs[7] = '{1'b0, 3'd3, 4'd8,  12'h044, 4, 2};
`else
    vecs[0] = '{1'b0, 3'd0, 4'd5,  12'h005, 2, 0};
    vecs[1] = '{1'b0, 3'd7, 4'd15, 12'h780, 9, 0};
    vecs[2] = '{1'b1, 3'd3, 4'd8,  12'hFC0, 5, 1};
    vecs[3] = '{1'b1, 3'd5, 4'd0,  12'h000, 7, 4};
    vecs[4] = '{1'b1, 3'd0, 4'd1,  12'hFFF, 2, 0};
    vecs[5] = '{1'b0, 3'd4, 4'd9,  12'h090, 6, 0};
    vecs[6] = '{1'b1, 3'd7, 4'd15, 12'h880, 9, 0};
    vecs[7] = '{1'b0, 3'd3, 4'd8,  12'h040, 5, 2};
`endif
    rst_n = 1'b0; in_valid = 1'b0; in_s = 1'b0; in_e = '0; in_f = '0; out_ready = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_d", 32'(out_d), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_word(vecs[i]);

    reset_midflight(1'b0, 3'd6, 4'd15, 3);
    reset_midflight(1'b1, 3'd1, 4'd3, 4);

    back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
